// File: rtl/csr_unit.sv
// Machine-mode Zicsr unit: fixed CSR set, 64-bit mcycle/minstret with inhibit.
// Registered write-back one cycle after the request; illegal accesses have no side effects.
module csr_unit #(
  parameter int          XLEN        = 32,
  parameter logic [63:0] HARTID      = '0,
  parameter logic [63:0] RESET_MTVEC = '0
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_valid,
  input  logic [11:0]     i_csr_addr,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rs1_addr_uimm,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_instret,
  output logic            o_rd_we,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_illegal
);

  localparam logic [1:0] MXL = (XLEN == 32) ? 2'd1 : 2'd2;
  localparam logic [XLEN-1:0] MISA = {MXL, {(XLEN-11){1'b0}}, 9'h100};
  localparam logic [XLEN-1:0] MTVEC_RST = XLEN'(RESET_MTVEC) & ~XLEN'(3);

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic            cy_q, cy_d, ir_q, ir_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic            rd_we_q, rd_we_d, illegal_q, illegal_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic [XLEN-1:0] operand, old_val, new_val;
  logic            impl, wr_req, illegal, do_wr;

  // Read mux and address decode
  always_comb begin
    impl    = 1'b1;
    old_val = '0;
    case (i_csr_addr)
      12'hF11, 12'hF12, 12'hF13: old_val = '0;
      12'hF14: old_val = XLEN'(HARTID);
      12'hC00, 12'hB00: old_val = XLEN'(mcycle_q);
      12'hC02, 12'hB02: old_val = XLEN'(minstret_q);
      12'hC80, 12'hB80: begin
        impl    = (XLEN == 32);
        old_val = XLEN'(mcycle_q[63:32]);
      end
      12'hC82, 12'hB82: begin
        impl    = (XLEN == 32);
        old_val = XLEN'(minstret_q[63:32]);
      end
      12'h300: old_val = XLEN'({2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0});
      12'h301: old_val = MISA;
      12'h305: old_val = mtvec_q;
      12'h320: old_val = XLEN'({ir_q, 1'b0, cy_q});
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      default: impl = 1'b0;
    endcase
  end

  always_comb begin
    operand = i_funct3[2] ? XLEN'(i_rs1_addr_uimm) : i_rs1_data;
    wr_req  = (i_funct3[1:0] == 2'b01) || (i_rs1_addr_uimm != 5'd0);
    illegal = i_valid & ((i_funct3[1:0] == 2'b00) | ~impl |
              (wr_req & (i_csr_addr[11:10] == 2'b11)));
    do_wr   = i_valid & ~illegal & wr_req;
    case (i_funct3[1:0])
      2'b10:   new_val = old_val | operand;
      2'b11:   new_val = old_val & ~operand;
      default: new_val = operand;
    endcase
  end

  // State update; a counter write overrides that cycle's increment
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    cy_d       = cy_q;
    ir_d       = ir_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = cy_q ? mcycle_q : mcycle_q + 64'd1;
    minstret_d = (i_instret && !ir_q) ? minstret_q + 64'd1 : minstret_q;
    if (do_wr) begin
      case (i_csr_addr)
        12'h300: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        12'h305: mtvec_d = new_val & ~XLEN'(3);
        12'h320: begin
          cy_d = new_val[0];
          ir_d = new_val[2];
        end
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d = new_val & ~XLEN'(3);
        12'h342: mcause_d = new_val;
        12'h343: mtval_d = new_val;
        12'hB00: mcycle_d = (XLEN == 32) ?
          {mcycle_q[63:32], new_val[31:0]} : 64'(new_val);
        12'hB02: minstret_d = (XLEN == 32) ?
          {minstret_q[63:32], new_val[31:0]} : 64'(new_val);
        12'hB80: mcycle_d = {new_val[31:0], mcycle_q[31:0]};
        12'hB82: minstret_d = {new_val[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    illegal_d = illegal;
    rd_we_d   = i_valid & ~illegal & (i_rd_addr != 5'd0);
    rd_addr_d = rd_we_d ? i_rd_addr : 5'd0;
    rd_data_d = rd_we_d ? old_val : '0;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      cy_q       <= 1'b0;
      ir_q       <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      rd_we_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      cy_q       <= cy_d;
      ir_q       <= ir_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      rd_we_q    <= rd_we_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign o_rd_we   = rd_we_q;
  assign o_rd_addr = rd_addr_q;
  assign o_rd_data = rd_data_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: RV32 and RV64 instances, queued expectations
// checked by per-instance monitors on the falling edge.
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_instret, a_we, a_ill;
  logic [11:0] a_addr;
  logic [2:0]  a_f3;
  logic [4:0]  a_uimm, a_rd, a_rd_o;
  logic [31:0] a_rs1, a_data;

  logic        b_valid, b_instret, b_we, b_ill;
  logic [11:0] b_addr;
  logic [2:0]  b_f3;
  logic [4:0]  b_uimm, b_rd, b_rd_o;
  logic [63:0] b_rs1, b_data;

  csr_unit #(.XLEN(32), .HARTID(64'd3), .RESET_MTVEC(64'h107)) u32 (
    .i_clk(clk), .i_nrst(rst_n), .i_valid(a_valid),
    .i_csr_addr(a_addr), .i_funct3(a_f3), .i_rs1_addr_uimm(a_uimm),
    .i_rd_addr(a_rd), .i_rs1_data(a_rs1), .i_instret(a_instret),
    .o_rd_we(a_we), .o_rd_addr(a_rd_o), .o_rd_data(a_data),
    .o_illegal(a_ill));

  csr_unit #(.XLEN(64), .HARTID(64'd0), .RESET_MTVEC(64'h0)) u64 (
    .i_clk(clk), .i_nrst(rst_n), .i_valid(b_valid),
    .i_csr_addr(b_addr), .i_funct3(b_f3), .i_rs1_addr_uimm(b_uimm),
    .i_rd_addr(b_rd), .i_rs1_data(b_rs1), .i_instret(b_instret),
    .o_rd_we(b_we), .o_rd_addr(b_rd_o), .o_rd_data(b_data),
    .o_illegal(b_ill));

  typedef struct {
    bit          we;
    bit          ill;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
  localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

  task automatic cmp(input exp_t e, input logic we, input logic ill,
                     input logic [4:0] rd, input logic [63:0] d);
    checks++;
    if (we !== e.we || ill !== e.ill || (e.we && rd !== e.rd) ||
        (e.we && e.chk && d !== e.data)) begin
      errors++;
      $display("FAIL %s: got we=%b ill=%b rd=%0d data=%h, want we=%b ill=%b rd=%0d data=%h",
               e.name, we, ill, rd, d, e.we, e.ill, e.rd, e.data);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (a_we || a_ill)) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected32: got we=%b ill=%b data=%h, want none",
                 a_we, a_ill, a_data);
      end else begin
        cmp(q32.pop_front(), a_we, a_ill, a_rd_o, {32'h0, a_data});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (b_we || b_ill)) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected64: got we=%b ill=%b data=%h, want none",
                 b_we, b_ill, b_data);
      end else begin
        cmp(q64.pop_front(), b_we, b_ill, b_rd_o, b_data);
      end
    end
  end

  task automatic op(input string name, input bit w64, input logic [2:0] f3,
                    input logic [11:0] addr, input logic [4:0] rs1,
                    input logic [4:0] rd, input logic [63:0] d,
                    input bit instret, input bit ill,
                    input logic [63:0] exp_data, input bit chk_data);
    exp_t e;
    @(negedge clk);
    a_valid = !w64; a_f3 = f3; a_addr = addr; a_uimm = rs1; a_rd = rd;
    a_rs1 = d[31:0]; a_instret = !w64 && instret;
    b_valid = w64; b_f3 = f3; b_addr = addr; b_uimm = rs1; b_rd = rd;
    b_rs1 = d; b_instret = w64 && instret;
    if (ill || rd != 5'd0) begin
      e.we = !ill; e.ill = ill; e.rd = rd; e.data = exp_data;
      e.chk = chk_data; e.name = name;
      if (w64) q64.push_back(e);
      else q32.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      a_instret = 1'b0; b_instret = 1'b0;
    end
  endtask

  initial begin
    a_valid = 0; a_instret = 0; a_addr = 0; a_f3 = 0; a_uimm = 0;
    a_rd = 0; a_rs1 = 0;
    b_valid = 0; b_instret = 0; b_addr = 0; b_f3 = 0; b_uimm = 0;
    b_rd = 0; b_rs1 = 0;
    #12;
    chk("rst_we32", {63'h0, a_we}, 64'h0);
    chk("rst_data32", {32'h0, a_data}, 64'h0);
    chk("rst_ill32", {63'h0, a_ill}, 64'h0);
    chk("rst_we64", {63'h0, b_we}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // RV32 register behaviour
    op("mstatus_rst", 0, RS, 12'h300, 0, 5, 0, 0, 0, 64'h1800, 1);
    op("misa32", 0, RS, 12'h301, 0, 6, 0, 0, 0, 64'h40000100, 1);
    op("mscratch_rw", 0, RW, 12'h340, 1, 1, 64'hDEADBEEF, 0, 0, 64'h0, 1);
    op("mscratch_rsi", 0, RSI, 12'h340, 5'h10, 2, 0, 0, 0, 64'hDEADBEEF, 1);
    op("mscratch_rci", 0, RCI, 12'h340, 5'h0F, 3, 0, 0, 0, 64'hDEADBEFF, 1);
    op("mscratch_rd", 0, RS, 12'h340, 0, 4, 0, 0, 0, 64'hDEADBEF0, 1);
    op("mstatus_wr", 0, RW, 12'h300, 1, 7, 64'hFFFFFFFF, 0, 0, 64'h1800, 1);
    op("mstatus_warl", 0, RS, 12'h300, 0, 7, 0, 0, 0, 64'h1888, 1);
    op("mtvec_rst", 0, RW, 12'h305, 1, 8, 64'h1003, 0, 0, 64'h104, 1);
    op("mtvec_warl", 0, RS, 12'h305, 0, 8, 0, 0, 0, 64'h1000, 1);
    op("misa_wr", 0, RW, 12'h301, 1, 9, 64'h0, 0, 0, 64'h40000100, 1);
    op("misa_keep", 0, RS, 12'h301, 0, 9, 0, 0, 0, 64'h40000100, 1);
    op("mcinh_wr", 0, RW, 12'h320, 1, 10, 64'hFF, 0, 0, 64'h0, 1);
    op("mcinh_warl", 0, RC, 12'h320, 1, 10, 64'hFF, 0, 0, 64'h5, 1);
    op("mcinh_clr", 0, RS, 12'h320, 0, 10, 0, 0, 0, 64'h0, 1);
    op("mhartid", 0, RS, 12'hF14, 0, 11, 0, 0, 0, 64'h3, 1);

    // Illegal accesses
    op("ill_hartid_w", 0, RW, 12'hF14, 1, 1, 64'h5, 0, 1, 0, 0);
    op("ill_cycle_w", 0, RW, 12'hC00, 1, 1, 64'h5, 0, 1, 0, 0);
    op("ill_f3_100", 0, 3'b100, 12'h340, 1, 12, 0, 0, 1, 0, 0);
    op("ill_f3_000", 0, 3'b000, 12'h340, 1, 12, 0, 0, 1, 0, 0);
    op("ill_addr", 0, RS, 12'h7C0, 0, 13, 0, 0, 1, 0, 0);
    op("cycle_rd", 0, RS, 12'hC00, 0, 15, 0, 0, 0, 0, 0);
    op("mscratch_kept", 0, RS, 12'h340, 0, 4, 0, 0, 0, 64'hDEADBEF0, 1);

    // RV32 counter halves and wrap
    op("mcycle_lo_w", 0, RW, 12'hB00, 1, 0, 64'hFFFFFFFF, 0, 0, 0, 0);
    op("mcycle_hi_w", 0, RW, 12'hB80, 1, 0, 64'h0, 0, 0, 0, 0);
    idle(1);
    op("mcycleh_wrap", 0, RS, 12'hB80, 0, 16, 0, 0, 0, 64'h1, 1);
    op("mcycle_lo", 0, RS, 12'hB00, 0, 16, 0, 0, 0, 64'h1, 1);
    op("cycle_alias", 0, RS, 12'hC00, 0, 16, 0, 0, 0, 64'h2, 1);
    op("cycleh_alias", 0, RS, 12'hC80, 0, 16, 0, 0, 0, 64'h1, 1);
    op("cy_set", 0, RWI, 12'h320, 5'd1, 0, 0, 0, 0, 0, 0);
    op("mcycle_55", 0, RW, 12'hB00, 1, 0, 64'h55, 0, 0, 0, 0);
    idle(10);
    op("cy_frozen", 0, RS, 12'hB00, 0, 17, 0, 0, 0, 64'h55, 1);
    op("cy_frozen2", 0, RS, 12'hC00, 0, 18, 0, 0, 0, 64'h55, 1);
    op("cy_clr", 0, RWI, 12'h320, 5'd0, 0, 0, 0, 0, 0, 0);

    // RV64
    op("misa64", 1, RS, 12'h301, 0, 5, 0, 0, 0, 64'h8000000000000100, 1);
    op("ill_cycleh64", 1, RS, 12'hC80, 0, 6, 0, 0, 1, 0, 0);
    op("ill_minstreth64", 1, RS, 12'hB82, 0, 6, 0, 0, 1, 0, 0);
    op("minstret_w", 1, RW, 12'hB02, 1, 0, 64'h5, 1, 0, 0, 0);
    op("minstret_5", 1, RS, 12'hB02, 0, 7, 0, 1, 0, 64'h5, 1);
    op("minstret_6", 1, RS, 12'hB02, 0, 8, 0, 0, 0, 64'h6, 1);
    op("mcycle64_w", 1, RW, 12'hB00, 1, 0, 64'h100, 0, 0, 0, 0);
    op("mcycle64_n", 1, RS, 12'hB00, 0, 9, 0, 0, 0, 64'h100, 1);
    op("mcycle64_n1", 1, RS, 12'hC00, 0, 10, 0, 0, 0, 64'h101, 1);
    op("mepc64_w", 1, RW, 12'h341, 1, 11, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 1);
    op("mepc64_warl", 1, RS, 12'h341, 0, 11, 0, 0, 0, 64'hFFFFFFFFFFFFFFFC, 1);
    op("mtvec64_rst", 1, RS, 12'h305, 0, 12, 0, 0, 0, 64'h0, 1);
    op("mcinh32_w", 0, RW, 12'h320, 1, 0, 64'h5, 0, 0, 0, 0);
    idle(3);

    // Reset mid-operation with a pulse in flight
    @(negedge clk);
    a_valid = 1; a_f3 = RS; a_addr = 12'h340; a_uimm = 0; a_rd = 7;
    @(posedge clk);
    #1;
    chk("pulse_before_rst", {63'h0, a_we}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {63'h0, a_we}, 64'h0);
    chk("mid_rst_rd", {59'h0, a_rd_o}, 64'h0);
    chk("mid_rst_data", {32'h0, a_data}, 64'h0);
    chk("mid_rst_ill", {63'h0, a_ill}, 64'h0);
    @(negedge clk);
    a_valid = 0;
    #1;
    rst_n = 1'b1;
    op("rst_mcycle", 0, RS, 12'hB00, 0, 3, 0, 0, 0, 64'h1, 1);
    op("rst_mscratch", 0, RS, 12'h340, 0, 3, 0, 0, 0, 64'h0, 1);
    op("rst_mstatus", 0, RS, 12'h300, 0, 3, 0, 0, 0, 64'h1800, 1);
    op("rst_mtvec", 0, RS, 12'h305, 0, 3, 0, 0, 0, 64'h104, 1);
    op("rst_mcinh", 0, RS, 12'h320, 0, 3, 0, 0, 0, 64'h0, 1);
    op("rst_minstret", 0, RS, 12'hB02, 0, 3, 0, 0, 0, 64'h0, 1);
    op("rst_mepc64", 1, RS, 12'h341, 0, 3, 0, 0, 0, 64'h0, 1);
    idle(4);

    chk("missing32", 64'(q32.size()), 64'h0);
    chk("missing64", 64'(q64.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
